// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with misaligned-access splitting into two aligned word beats

package tcore_param;
    typedef enum logic [1:0] {
        NO_SIZE   = 2'd0,
        BYTE      = 2'd1,
        HALF_WORD = 2'd2,
        WORD      = 2'd3
    } size_t;
endpackage

module load_store_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic                wr_en_i,
    input  tcore_param::size_t  rw_size_i,
    input  logic                ld_op_sign_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                stall_o,
    output logic                done_o,
    output logic                err_o,
    output logic [31:0]         rd_data_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [3:0]          mem_be_o,
    output logic [31:0]         mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i
);
    import tcore_param::*;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, sign_q, split_q, err_q;
    size_t       size_q;
    logic [1:0]  off_q;
    logic [29:0] base_q;
    logic [7:0]  be_q;
    logic [63:0] wdata_q;
    logic [31:0] beat0_q, rd_data_q;

    logic        accept, misaligned;
    logic [3:0]  size_mask;
    logic [7:0]  be_in;
    logic [63:0] wdata_in;
    logic [63:0] ld_pair, ld_shift;
    logic [31:0] ld_result;
    logic        ld_commit;

    assign accept = (state_q == S_IDLE) && valid_i && (rw_size_i != NO_SIZE);

    // Alignment check and lane placement of the incoming request
    always_comb begin
        misaligned = 1'b0;
        size_mask  = 4'b0000;
        case (rw_size_i)
            BYTE:      size_mask = 4'b0001;
            HALF_WORD: begin size_mask = 4'b0011; misaligned = addr_i[0]; end
            WORD:      begin size_mask = 4'b1111; misaligned = (addr_i[1:0] != 2'b00); end
            default:   size_mask = 4'b0000;
        endcase
        be_in    = {4'b0000, size_mask} << addr_i[1:0];
        wdata_in = {32'h0, wdata_i} << {addr_i[1:0], 3'b000};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (misaligned && !SPLIT_EN) ? S_DONE : S_REQ0;
            S_REQ0:  if (mem_gnt_i) state_d = S_WAIT0;
            S_WAIT0: if (mem_rvalid_i) state_d = split_q ? S_REQ1 : S_DONE;
            S_REQ1:  if (mem_gnt_i) state_d = S_WAIT1;
            S_WAIT1: if (mem_rvalid_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Load result: realign the beat pair, truncate to size and extend
    always_comb begin
        ld_pair   = (state_q == S_WAIT1) ? {mem_rdata_i, beat0_q} : {32'h0, mem_rdata_i};
        ld_shift  = ld_pair >> {off_q, 3'b000};
        ld_result = ld_shift[31:0];
        case (size_q)
            BYTE:      ld_result = {{24{sign_q & ld_shift[7]}}, ld_shift[7:0]};
            HALF_WORD: ld_result = {{16{sign_q & ld_shift[15]}}, ld_shift[15:0]};
            default:   ld_result = ld_shift[31:0];
        endcase
        ld_commit = !we_q && mem_rvalid_i &&
                    (((state_q == S_WAIT0) && !split_q) || (state_q == S_WAIT1));
    end

    // Request capture, first-beat buffer and load result register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= NO_SIZE;
            off_q     <= 2'b00;
            base_q    <= 30'h0;
            be_q      <= 8'h0;
            wdata_q   <= 64'h0;
            beat0_q   <= 32'h0;
            rd_data_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= wr_en_i;
                sign_q  <= ld_op_sign_i;
                split_q <= misaligned && SPLIT_EN;
                err_q   <= misaligned && !SPLIT_EN;
                size_q  <= rw_size_i;
                off_q   <= addr_i[1:0];
                base_q  <= addr_i[31:2];
                be_q    <= be_in;
                wdata_q <= wdata_in;
            end
            if ((state_q == S_WAIT0) && mem_rvalid_i) beat0_q <= mem_rdata_i;
            if (ld_commit) rd_data_q <= ld_result;
        end
    end

    // Memory port drive; everything is zero outside the request states
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'h0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (state_q == S_REQ0) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = {base_q, 2'b00};
            mem_be_o    = be_q[3:0];
            mem_wdata_o = we_q ? wdata_q[31:0] : 32'h0;
        end else if (state_q == S_REQ1) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = {base_q + 30'd1, 2'b00};
            mem_be_o    = be_q[7:4];
            mem_wdata_o = we_q ? wdata_q[63:32] : 32'h0;
        end
        mem_we_o = mem_req_o & we_q;
    end

    assign stall_o   = accept || ((state_q != S_IDLE) && (state_q != S_DONE));
    assign done_o    = (state_q == S_DONE);
    assign err_o     = (state_q == S_DONE) && err_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven self-checking bench for load_store_unit

module tb_load_store_unit;
    import tcore_param::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, valid2, wr, sign, gnt, rvalid;
    size_t       size;
    logic [31:0] addr, wdata, rdata;

    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] rd_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        stall_b, done_b, err_b, mem_req_b, mem_we_b;
    logic [31:0] rd_data_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;

    load_store_unit #(.SPLIT_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .wr_en_i(wr), .rw_size_i(size),
        .ld_op_sign_i(sign), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
        .err_o(err), .rd_data_o(rd_data), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
    );

    load_store_unit #(.SPLIT_EN(1'b0)) dut_nosplit (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid2), .wr_en_i(wr), .rw_size_i(size),
        .ld_op_sign_i(sign), .addr_i(addr), .wdata_i(wdata), .stall_o(stall_b), .done_o(done_b),
        .err_o(err_b), .rd_data_o(rd_data_b), .mem_req_o(mem_req_b), .mem_we_o(mem_we_b),
        .mem_addr_o(mem_addr_b), .mem_be_o(mem_be_b), .mem_wdata_o(mem_wdata_b),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        size_t       size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          gdly;
        int          beats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] exp_rd;
        int          lat;
    } vec_t;

    vec_t vec[11];

    task automatic run_txn(input vec_t v, input int idx);
        int          cyc, beat, wcnt;
        bit          pend, done_seen;
        logic [31:0] pdata;
        @(negedge clk);
        valid = 1'b1; wr = v.wr; size = v.size; sign = v.sign;
        addr = v.addr; wdata = v.wdata; gnt = 1'b0; rvalid = 1'b0;
        #1 chk($sformatf("v%0d stall_accept", idx), stall, 1);
        @(negedge clk);
        valid = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h5A5A_5A5A;
        cyc = 1; beat = 0; wcnt = 0; pend = 0; done_seen = 0; pdata = 0;
        while (!done_seen && cyc <= 20) begin
            gnt    = 1'b0;
            rvalid = pend;
            rdata  = pend ? pdata : 32'h0;
            pend   = 0;
            #1;
            if (done) begin
                chk($sformatf("v%0d latency", idx), cyc, v.lat);
                chk($sformatf("v%0d err", idx), err, 0);
                chk($sformatf("v%0d rd_data", idx), rd_data, v.exp_rd);
                chk($sformatf("v%0d req_in_done", idx), mem_req, 0);
                done_seen = 1;
            end else begin
                chk($sformatf("v%0d stall_busy c%0d", idx, cyc), stall, 1);
                if (mem_req) begin
                    chk($sformatf("v%0d b%0d we", idx, beat), mem_we, v.wr);
                    chk($sformatf("v%0d b%0d addr", idx, beat), mem_addr, beat == 0 ? v.a0 : v.a1);
                    chk($sformatf("v%0d b%0d be", idx, beat), mem_be, beat == 0 ? v.be0 : v.be1);
                    chk($sformatf("v%0d b%0d wdata", idx, beat), mem_wdata, beat == 0 ? v.wd0 : v.wd1);
                    if (wcnt < v.gdly) begin
                        wcnt++;
                    end else begin
                        gnt   = 1'b1;
                        pend  = 1;
                        pdata = (beat == 0) ? v.rd0 : v.rd1;
                        beat++;
                        wcnt  = 0;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        gnt = 1'b0; rvalid = 1'b0;
        if (!done_seen) chk($sformatf("v%0d timeout", idx), 0, 1);
        chk($sformatf("v%0d beats", idx), beat, v.beats);
        #1;
        chk($sformatf("v%0d done_drop", idx), done, 0);
        chk($sformatf("v%0d stall_idle", idx), stall, 0);
        chk($sformatf("v%0d rd_hold", idx), rd_data, v.exp_rd);
    endtask

    initial begin
        vec[0]  = '{0, WORD,      0, 32'h1000,     32'h0,        32'hAABBCCDD, 32'h0,        0, 1, 32'h1000,     4'hF, 32'h0,        32'h0,    4'h0, 32'h0,        32'hAABBCCDD, 3};
        vec[1]  = '{0, BYTE,      1, 32'h1003,     32'h0,        32'h80000000, 32'h0,        0, 1, 32'h1000,     4'h8, 32'h0,        32'h0,    4'h0, 32'h0,        32'hFFFFFF80, 3};
        vec[2]  = '{0, BYTE,      0, 32'h1003,     32'h0,        32'h80000000, 32'h0,        0, 1, 32'h1000,     4'h8, 32'h0,        32'h0,    4'h0, 32'h0,        32'h00000080, 3};
        vec[3]  = '{0, WORD,      0, 32'h1002,     32'h0,        32'hAABBCCDD, 32'h11223344, 0, 2, 32'h1000,     4'hC, 32'h0,        32'h1004, 4'h3, 32'h0,        32'h3344AABB, 5};
        vec[4]  = '{1, HALF_WORD, 0, 32'h1003,     32'h0000BEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 32'h1000,     4'h8, 32'hEF000000, 32'h1004, 4'h1, 32'h000000BE, 32'h3344AABB, 5};
        vec[5]  = '{0, HALF_WORD, 1, 32'h2002,     32'h0,        32'h80010000, 32'h0,        2, 1, 32'h2000,     4'hC, 32'h0,        32'h0,    4'h0, 32'h0,        32'hFFFF8001, 5};
        vec[6]  = '{1, BYTE,      0, 32'h2001,     32'h123456A5, 32'h0,        32'h0,        0, 1, 32'h2000,     4'h2, 32'h3456A500, 32'h0,    4'h0, 32'h0,        32'hFFFF8001, 3};
        vec[7]  = '{0, WORD,      0, 32'hFFFFFFFF, 32'h0,        32'h44332211, 32'h88776655, 0, 2, 32'hFFFFFFFC, 4'h8, 32'h0,        32'h0,    4'h7, 32'h0,        32'h77665544, 5};
        vec[8]  = '{0, HALF_WORD, 0, 32'h3000,     32'h0,        32'h1234FFFE, 32'h0,        0, 1, 32'h3000,     4'h3, 32'h0,        32'h0,    4'h0, 32'h0,        32'h0000FFFE, 3};
        vec[9]  = '{1, WORD,      0, 32'h4000,     32'hCAFEF00D, 32'h0,        32'h0,        1, 1, 32'h4000,     4'hF, 32'hCAFEF00D, 32'h0,    4'h0, 32'h0,        32'h0000FFFE, 4};
        vec[10] = '{0, HALF_WORD, 1, 32'h5003,     32'h0,        32'h7F000000, 32'h000000FF, 0, 2, 32'h5000,     4'h8, 32'h0,        32'h5004, 4'h1, 32'h0,        32'hFFFFFF7F, 5};

        rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0; wr = 1'b0; size = NO_SIZE; sign = 1'b0;
        addr = 32'h0; wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst req", mem_req, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst be", mem_be, 0);
        chk("rst wdata", mem_wdata, 0);
        chk("rst rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // NO_SIZE requests are ignored without stalling
        @(negedge clk);
        valid = 1'b1; size = NO_SIZE; addr = 32'h1000;
        #1 chk("nosize stall", stall, 0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("nosize req", mem_req, 0);
        chk("nosize stall_after", stall, 0);

        for (int i = 0; i < 11; i++) run_txn(vec[i], i);

        // Misaligned store with splitting disabled: error pulse, no memory traffic
        @(negedge clk);
        valid2 = 1'b1; wr = 1'b1; size = WORD; sign = 1'b0; addr = 32'h1001; wdata = 32'h12345678;
        #1 chk("nosplit stall_accept", stall_b, 1);
        @(negedge clk);
        valid2 = 1'b0;
        #1;
        chk("nosplit done", done_b, 1);
        chk("nosplit err", err_b, 1);
        chk("nosplit req", mem_req_b, 0);
        @(negedge clk);
        #1;
        chk("nosplit done_drop", done_b, 0);
        chk("nosplit err_drop", err_b, 0);
        chk("nosplit req_after", mem_req_b, 0);
        chk("nosplit stall_idle", stall_b, 0);

        // Reset during WAIT1 of a split load, then a stale response
        @(negedge clk);
        valid = 1'b1; wr = 1'b0; size = WORD; sign = 1'b0; addr = 32'h1002;
        @(negedge clk);
        valid = 1'b0;
        #1 chk("rstmid req0", mem_req, 1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAABBCCDD;
        @(negedge clk);
        rvalid = 1'b0;
        #1 chk("rstmid req1 addr", mem_addr, 32'h1004);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rst_n = 1'b0;
        #1 chk("rstmid wait1 stall", stall, 1);
        @(negedge clk);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h11223344;
        #1;
        chk("rstmid done", done, 0);
        chk("rstmid stall", stall, 0);
        chk("rstmid rd_data", rd_data, 0);
        chk("rstmid req", mem_req, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("rstmid stale done", done, 0);
        chk("rstmid stale rd_data", rd_data, 0);
        chk("rstmid stale stall", stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SPLIT_EN, default 1, meaning: 1 = misaligned accesses split into two aligned word beats, 0 = misaligned accesses raise err_o and make no memory request.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 valid_i  input  1  execute stage presents a memory operation this cycle.
REQ-005 wr_en_i  input  1  1 = store, 0 = load.
REQ-006 rw_size_i  input  tcore_param size type  NO_SIZE, BYTE, HALF_WORD or WORD.
REQ-007 ld_op_sign_i  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-008 addr_i  input  32  byte address (ALU result).
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 stall_o  output  1  unit busy; pipeline holds.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  one-cycle misalign-error pulse, coincident with done_o.
REQ-013 rd_data_o  output  32  extended load result.
REQ-014 mem_req_o, mem_we_o  output  1 each  memory request and write flag.
REQ-015 mem_addr_o  output  32  word-aligned address, bits [1:0] = 0.
REQ-016 mem_be_o  output  4  byte enables, bit n = byte lane n.
REQ-017 mem_wdata_o  output  32  lane-aligned store data.
REQ-018 mem_gnt_i, mem_rvalid_i  input  1 each  request accepted / response (load or store) returned.
REQ-019 mem_rdata_i  input  32  load response data.

Function
REQ-020 States SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
REQ-021 In IDLE, valid_i with rw_size_i != NO_SIZE SHALL latch all inputs and go to REQ0; NO_SIZE SHALL be ignored with stall_o low.
REQ-022 Misaligned means HALF_WORD with addr[0]=1, or WORD with addr[1:0]!=0; BYTE is never misaligned.
REQ-023 With SPLIT_EN=0 and a misaligned access, the FSM SHALL go from IDLE to DONE with err_o=1 and no mem_req_o.
REQ-024 mem_req_o SHALL be high exactly in REQ0/REQ1; address, we, be and wdata SHALL be held stable until mem_gnt_i.
REQ-025 REQ0 -> WAIT0 on mem_gnt_i; WAIT0 -> REQ1 on mem_rvalid_i if split, else DONE; REQ1 -> WAIT1 on mem_gnt_i; WAIT1 -> DONE on mem_rvalid_i; DONE -> IDLE unconditionally.
REQ-026 At most one request SHALL be outstanding; mem_rvalid_i in IDLE, REQ0, REQ1 or DONE SHALL be ignored.
REQ-027 Beat 0 SHALL address {addr[31:2],2'b00}, beat 1 that address + 4 (wraps modulo 2^32).
REQ-028 Size mask 0001/0011/1111 SHALL be shifted left by addr[1:0] into 8 bits; low nibble -> beat-0 mem_be_o, high nibble -> beat-1 mem_be_o.
REQ-029 wdata SHALL be shifted left by 8*addr[1:0] into 64 bits; low word -> beat-0 data, high word -> beat-1 data.
REQ-030 Load: {beat1, beat0} SHALL be shifted right by 8*addr[1:0], truncated to size, extended per ld_op_sign_i; beat1 treated as 0 if unsplit.
REQ-031 stall_o SHALL be high in every state except IDLE and DONE, and combinationally high in IDLE during the accepting cycle.
REQ-032 done_o SHALL be high exactly in DONE; rd_data_o SHALL update on entry to DONE and hold until the next load completes; stores leave rd_data_o unchanged.
REQ-033 Latency: aligned access with gnt same cycle as req and rvalid next cycle SHALL give done_o 3 cycles after acceptance; split access 5 cycles.

Reset
REQ-034 rst_ni low at a clock edge SHALL force IDLE, rd_data_o=0, all outputs 0, including mid-transaction; a later stale mem_rvalid_i SHALL be ignored.

Verification
REQ-035 Aligned lw 0x1000, rdata 0xAABBCCDD -> one beat, mem_be_o=1111, rd_data_o=0xAABBCCDD, done_o 3 cycles after accept.
REQ-036 lb signed at 0x1003, rdata 0x80000000 -> rd_data_o=0xFFFFFF80; lbu same -> 0x00000080.
REQ-037 Split lw at 0x1002, beats 0xAABBCCDD then 0x11223344 -> addrs 0x1000/0x1004, be 1100/0011, rd_data_o=0x3344AABB, done_o 5 cycles after accept.
REQ-038 Split sh at 0x1003, wdata 0x0000BEEF -> beat0 be 1000 data 0xEF000000, beat1 be 0001 data 0x000000BE.
REQ-039 SPLIT_EN=0, sw at 0x1001 -> no mem_req_o, done_o and err_o high one cycle after accept.
REQ-040 rst_ni low during WAIT1, then mem_rvalid_i -> IDLE, no done_o, rd_data_o=0.
